// File: rtl/quad_enc_dec_pkg.sv
// Shared types and helpers for the quadrature encoder decoder.
package quad_enc_dec_pkg;

   typedef logic [1:0] phase_t;

   typedef enum logic {
      PRIME,
      TRACK
   } state_t;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   // Gray order {a,b}: 00,10,11,01 maps to phases 0,1,2,3
   function automatic phase_t ab2phase(input logic a, input logic b);
      phase_t ph;
      case ({a, b})
         2'b00:   ph = 2'd0;
         2'b10:   ph = 2'd1;
         2'b11:   ph = 2'd2;
         default: ph = 2'd3;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/quad_enc_dec_sync_nff.sv
// N-flop synchronizer for one asynchronous input, synchronous active-high reset.
module sync_nff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/quad_enc_dec.sv
// x4 quadrature decoder: synchronizers, optional glitch filter (QUAD_ENC_DEC_FILTER_EN),
// PRIME/TRACK state machine and signed wrapping position counter.
module quad_enc_dec
   import quad_enc_dec_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a,
   input  logic                    b,
   input  logic                    clr,
   output logic signed [CNT_W-1:0] pos,
   output logic                    step,
   output logic                    dir,
   output logic                    err
);

`ifdef QUAD_ENC_DEC_FILTER_EN
   localparam bit FILT_EN = 1'b1;
`else
   localparam bit FILT_EN = 1'b0;
`endif

   // Extra PRIME cycles let the filter see a settled synchronizer output
   localparam int unsigned PRIME_LEN = SYNC_STAGES + (FILT_EN ? FILT_CYC : 0);
   localparam int unsigned PW        = $clog2(PRIME_LEN + 1);

   logic          a_s;
   logic          b_s;
   logic [1:0]    ab_s;
   state_t        state;
   logic [PW-1:0] pcnt;
   logic          prime_done;
   phase_t        prev_phase;
   phase_t        sync_phase;
   phase_t        cur_phase;
   phase_t        delta;

   sync_nff #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk (clk),
      .rst (rst),
      .d   (a),
      .q   (a_s)
   );

   sync_nff #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk (clk),
      .rst (rst),
      .d   (b),
      .q   (b_s)
   );

   assign ab_s       = {a_s, b_s};
   assign sync_phase = ab2phase(a_s, b_s);
   assign prime_done = (state == PRIME) && (pcnt == PW'(PRIME_LEN));

`ifdef QUAD_ENC_DEC_FILTER_EN
   localparam int unsigned FW = $clog2(FILT_CYC + 1);

   logic [1:0]    filt;
   logic [FW-1:0] fcnt [2];

   // A channel's level moves only after FILT_CYC consecutive mismatching samples
   always_ff @(posedge clk) begin
      if (rst) begin
         filt <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fcnt[i] <= '0;
         end
      end else if (prime_done) begin
         filt <= ab_s;
         for (int unsigned i = 0; i < 2; i++) begin
            fcnt[i] <= '0;
         end
      end else if (state == TRACK) begin
         for (int unsigned i = 0; i < 2; i++) begin
            if (ab_s[i] != filt[i]) begin
               if (fcnt[i] == FW'(FILT_CYC - 1)) begin
                  filt[i] <= ab_s[i];
                  fcnt[i] <= '0;
               end else begin
                  fcnt[i] <= fcnt[i] + FW'(1);
               end
            end else begin
               fcnt[i] <= '0;
            end
         end
      end
   end

   assign cur_phase = ab2phase(filt[1], filt[0]);
`else
   assign cur_phase = sync_phase;
`endif

   always_comb begin
      delta = cur_phase - prev_phase;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PRIME;
         pcnt       <= '0;
         prev_phase <= '0;
         pos        <= '0;
         step       <= 1'b0;
         dir        <= DIR_CW;
         err        <= 1'b0;
      end else begin
         step <= 1'b0;
         err  <= 1'b0;
         case (state)
            PRIME: begin
               if (prime_done) begin
                  prev_phase <= sync_phase;
                  state      <= TRACK;
               end else begin
                  pcnt <= pcnt + PW'(1);
               end
            end
            TRACK: begin
               prev_phase <= cur_phase;
               case (delta)
                  2'd1: begin
                     pos  <= pos + CNT_W'(1);
                     dir  <= DIR_CW;
                     step <= 1'b1;
                  end
                  2'd3: begin
                     pos  <= pos - CNT_W'(1);
                     dir  <= DIR_CCW;
                     step <= 1'b1;
                  end
                  2'd2: begin
                     err <= 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            default: begin
               state <= PRIME;
            end
         endcase
         // Clear overrides the count but leaves step/dir reporting the transition
         if (clr) begin
            pos <= '0;
         end
      end
   end

endmodule

// File: tb/tb_quad_enc_dec.sv
// Self-checking bench for quad_enc_dec: directed vector table, corner sequences and a
// randomized run against a sample-history reference model (16-bit and 4-bit counters).
`timescale 1ns/1ps
module tb_quad_enc_dec;

   localparam int N = 2;
   localparam int F = 4;
`ifdef QUAD_ENC_DEC_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif
   localparam int LAT = N + 1 + (FILT ? F : 0);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a = 1'b0;
   logic b = 1'b0;
   logic clr = 1'b0;

   logic signed [15:0] pos;
   logic               step, dir, err;
   logic signed [3:0]  pos4;
   logic               step4, dir4, err4;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   quad_enc_dec #(.CNT_W(16), .SYNC_STAGES(N), .FILT_CYC(F)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
      .pos(pos), .step(step), .dir(dir), .err(err)
   );

   quad_enc_dec #(.CNT_W(4), .SYNC_STAGES(N), .FILT_CYC(F)) dut4 (
      .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
      .pos(pos4), .step(step4), .dir(dir4), .err(err4)
   );

   // Reference model: each input sample takes effect N edges after it is captured
   int   m_pos;
   logic m_step, m_dir, m_err;
   int   hq[$];
   bit   primed;
   int   nseen;
   int   prev_ph;
   int   f_lvl[2];
   int   f_cnt[2];
   int   s_ab, cur, dlt;

   function automatic int ph_of(input int ab);
      int r;
      case (ab)
         0:       r = 0;
         2:       r = 1;
         3:       r = 2;
         default: r = 3;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pos = 0; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0;
         hq.delete(); primed = 1'b0; nseen = 0; prev_ph = 0;
         f_lvl[0] = 0; f_lvl[1] = 0; f_cnt[0] = 0; f_cnt[1] = 0;
      end else begin
         m_step = 1'b0;
         m_err  = 1'b0;
         hq.push_back(a * 2 + b);
         if (hq.size() == N + 1) begin
            s_ab = hq.pop_front();
            nseen++;
            if (!primed) begin
               if (nseen == (FILT ? F + 1 : 1)) begin
                  primed = 1'b1;
                  prev_ph = ph_of(s_ab);
                  f_lvl[1] = s_ab / 2; f_lvl[0] = s_ab % 2;
                  f_cnt[0] = 0; f_cnt[1] = 0;
               end
            end else begin
               cur = FILT ? ph_of(f_lvl[1] * 2 + f_lvl[0]) : ph_of(s_ab);
               dlt = (cur - prev_ph + 4) % 4;
               if (dlt == 1) begin m_pos = m_pos + 1; m_dir = 1'b0; m_step = 1'b1; end
               else if (dlt == 3) begin m_pos = m_pos - 1; m_dir = 1'b1; m_step = 1'b1; end
               else if (dlt == 2) m_err = 1'b1;
               prev_ph = cur;
               if (FILT) begin
                  for (int i = 0; i < 2; i++) begin
                     if (((s_ab >> i) & 1) != f_lvl[i]) begin
                        f_cnt[i]++;
                        if (f_cnt[i] == F) begin f_lvl[i] = (s_ab >> i) & 1; f_cnt[i] = 0; end
                     end else begin
                        f_cnt[i] = 0;
                     end
                  end
               end
            end
         end
         if (clr) m_pos = 0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock; compare both DUTs against the model on the falling edge
   task automatic cyc();
      logic signed [15:0] e16;
      logic signed [3:0]  e4;
      @(negedge clk);
      e16 = 16'(m_pos);
      e4  = 4'(m_pos);
      chk("model_pos", pos, e16);
      chk("model_pos4", pos4, e4);
      chk("model_step", step, m_step);
      chk("model_dir", dir, m_dir);
      chk("model_err", err, m_err);
      chk("model_flags4", {step4, dir4, err4}, {m_step, m_dir, m_err});
   endtask

   task automatic drive_ph(input int p);
      case (p % 4)
         0:       begin a = 1'b0; b = 1'b0; end
         1:       begin a = 1'b1; b = 1'b0; end
         2:       begin a = 1'b1; b = 1'b1; end
         default: begin a = 1'b0; b = 1'b1; end
      endcase
   endtask

   function automatic int wrap4(input int v);
      return ((v % 16) + 16 + 8) % 16 - 8;
   endfunction

   typedef struct {
      int   ph;
      int   hold;
      int   e_pos;
      int   e_pos4;
      logic e_dir;
   } vec_t;

   vec_t tv[$];
   int   tp, tpos, nsteps, nerrs, lat;
   bit   found;
   int   rev[6] = '{1, 1, -1, -1, -1, 1};
   int   stp, rp;

   initial begin
      // Vector table: 3 CW cycles, 2 CCW cycles, then a mid-cycle reversal
      tp = 2; tpos = 0;
      for (int i = 0; i < 12; i++) begin
         tp = (tp + 1) % 4; tpos++;
         tv.push_back('{tp, 10, tpos, wrap4(tpos), 1'b0});
      end
      for (int i = 0; i < 8; i++) begin
         tp = (tp + 3) % 4; tpos--;
         tv.push_back('{tp, 10, tpos, wrap4(tpos), 1'b1});
      end
      for (int i = 0; i < 6; i++) begin
         tp = (tp + 4 + rev[i]) % 4; tpos += rev[i];
         tv.push_back('{tp, 10, tpos, wrap4(tpos), (rev[i] < 0)});
      end

      // Reset with both channels high; the level at release must not count
      rst = 1'b1; a = 1'b1; b = 1'b1;
      repeat (20) cyc();
      rst = 1'b0;
      nsteps = 0; nerrs = 0;
      for (int c = 0; c < 10; c++) begin cyc(); nsteps += step; nerrs += err; end
      chk("prime_steps", nsteps, 0);
      chk("prime_errs", nerrs, 0);
      chk("prime_pos", pos, 0);

      foreach (tv[i]) begin
         drive_ph(tv[i].ph);
         nsteps = 0;
         for (int c = 0; c < tv[i].hold; c++) begin cyc(); nsteps += step; end
         chk("vec_pos", pos, tv[i].e_pos);
         chk("vec_pos4", pos4, tv[i].e_pos4);
         chk("vec_dir", dir, tv[i].e_dir);
         chk("vec_steps", nsteps, 1);
      end

      // Edge-to-step latency
      tp = (tp + 1) % 4; tpos++;
      drive_ph(tp);
      lat = 0; found = 1'b0;
      for (int c = 1; c <= 20 && !found; c++) begin
         cyc();
         if (step) begin lat = c; found = 1'b1; end
      end
      chk("latency", lat, LAT);
      repeat (10) cyc();

      // Two-bit jump: single err pulse, no count, next edge relative to new phase
      tp = (tp + 2) % 4;
      drive_ph(tp);
      nsteps = 0; nerrs = 0;
      for (int c = 0; c < 12; c++) begin cyc(); nsteps += step; nerrs += err; end
      chk("jump_errs", nerrs, 1);
      chk("jump_steps", nsteps, 0);
      chk("jump_pos", pos, tpos);
      tp = (tp + 1) % 4; tpos++;
      drive_ph(tp);
      repeat (12) cyc();
      chk("after_jump_pos", pos, tpos);
      chk("after_jump_dir", dir, 0);

      // clr in the same cycle the step registers
      tp = (tp + 3) % 4;
      drive_ph(tp);
      repeat (LAT - 1) cyc();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_step", step, 1);
      chk("clr_pos", pos, 0);
      chk("clr_dir", dir, 1);
      tpos = 0;
      repeat (10) cyc();

`ifdef QUAD_ENC_DEC_FILTER_EN
      // Short glitch on a is swallowed by the filter
      a = ~a;
      repeat (3) cyc();
      a = ~a;
      nsteps = 0; nerrs = 0;
      for (int c = 0; c < 20; c++) begin cyc(); nsteps += step; nerrs += err; end
      chk("glitch_steps", nsteps, 0);
      chk("glitch_errs", nerrs, 0);
      chk("glitch_pos", pos, tpos);
`endif

      // Randomized traffic, mostly legal Gray steps, with a mid-run reset
      rp = tp;
      for (int seg = 0; seg < 2; seg++) begin
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) begin
               stp = ($urandom_range(0, 1) == 0) ? 1 : 3;
               rp = (rp + stp) % 4;
            end else begin
               rp = $urandom_range(0, 3);
            end
            drive_ph(rp);
            clr = ($urandom_range(0, 15) == 0);
            cyc();
            clr = 1'b0;
            repeat ($urandom_range(0, 3)) cyc();
         end
         if (seg == 0) begin
            rst = 1'b1;
            rp = $urandom_range(1, 3);
            drive_ph(rp);
            repeat (3) cyc();
            rst = 1'b0;
         end
      end
      repeat (20) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
